// File: rtl/rr_arb_64b.sv
// 64-requester round-robin arbiter with registered one-hot grant held until release.
// Optional watchdog forced release is built when ARB_WDT_EN is defined.
module rr_arb_64b #(
  parameter logic        RR_EN   = 1'b1,
  parameter int unsigned WDT_CYC = 256
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic [63:0] req_i,
  input  logic        rel_i,
  output logic [63:0] gnt_o,
  output logic        gnt_vld_o,
  output logic [5:0]  gnt_idx_o,
  output logic        to_o
);

  // Handshake: a requester holds req_i high; once gnt_vld_o rises the grant is
  // owned until the owner pulses rel_i (or the watchdog fires); the slot then
  // spends one cycle in IDLE before the next grant can be issued.
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  if (WDT_CYC < 2 || WDT_CYC > 65535) begin : g_wdt_range
    $error("rr_arb_64b: WDT_CYC out of range 2..65535");
  end

  state_t      state;
  logic [5:0]  ptr;
  logic [63:0] mask;
  logic [63:0] masked;
  logic [63:0] cand;
  logic [5:0]  win_idx;
  logic        wdt_hit;

  // Requests at or above the pointer take precedence; otherwise fall back to the full vector.
  always_comb begin
    mask    = RR_EN ? ({64{1'b1}} << ptr) : {64{1'b1}};
    masked  = req_i & mask;
    cand    = (|masked) ? masked : req_i;
    win_idx = '0;
    for (int i = 63; i >= 0; i--) begin
      if (cand[i]) win_idx = 6'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_o     <= '0;
      gnt_vld_o <= 1'b0;
      gnt_idx_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en_i && (|req_i)) begin
            gnt_o     <= 64'd1 << win_idx;
            gnt_idx_o <= win_idx;
            gnt_vld_o <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (rel_i || wdt_hit) begin
            gnt_o     <= '0;
            gnt_idx_o <= '0;
            gnt_vld_o <= 1'b0;
            ptr       <= gnt_idx_o + 6'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_WDT_EN
  logic [15:0] wdt_cnt;

  // A release on the limit cycle wins, so the timeout pulse stays low.
  assign wdt_hit = (state == GRANT) && !rel_i && (wdt_cnt == 16'(WDT_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wdt_cnt <= '0;
      to_o    <= 1'b0;
    end else begin
      to_o <= wdt_hit;
      if (state != GRANT) begin
        wdt_cnt <= '0;
      end else if (!rel_i) begin
        wdt_cnt <= wdt_cnt + 16'd1;
      end
    end
  end
`else
  assign wdt_hit = 1'b0;
  assign to_o    = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb_64b.sv
// Self-checking bench for rr_arb_64b: a round-robin instance and a fixed-priority
// instance share stimulus; grants are scored against a reference pointer model.
module tb_rr_arb_64b;
  localparam int WDT = 8;

  logic        clk_i   = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        en_i    = 1'b0;
  logic        rel_i   = 1'b0;
  logic [63:0] req_i   = '0;

  logic [63:0] gnt_o,     gnt_fp;
  logic        gnt_vld_o, vld_fp;
  logic [5:0]  gnt_idx_o, idx_fp;
  logic        to_o,      to_fp;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [5:0] exp_q[$];
  logic [5:0] m_ptr = '0;
  logic       prev_vld = 1'b0;

  always #5 clk_i = ~clk_i;

  rr_arb_64b #(.RR_EN(1'b1), .WDT_CYC(WDT)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .req_i(req_i), .rel_i(rel_i),
    .gnt_o(gnt_o), .gnt_vld_o(gnt_vld_o), .gnt_idx_o(gnt_idx_o), .to_o(to_o)
  );

  rr_arb_64b #(.RR_EN(1'b0), .WDT_CYC(WDT)) dut_fp (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .req_i(req_i), .rel_i(rel_i),
    .gnt_o(gnt_fp), .gnt_vld_o(vld_fp), .gnt_idx_o(idx_fp), .to_o(to_fp)
  );

  // Reference winner: scan upward from the pointer with wrap-around.
  function automatic logic [5:0] model_win(input logic [63:0] req, input logic [5:0] p);
    logic [5:0] i;
    logic [5:0] w;
    bit         found;
    w = '0;
    found = 0;
    for (int k = 0; k < 64; k++) begin
      i = p + 6'(k);
      if (!found && req[i]) begin
        w = i;
        found = 1;
      end
    end
    return w;
  endfunction

  // Scoreboard: every rising grant must match the oldest expected winner.
  always @(negedge clk_i) begin
    logic [5:0]  e;
    logic [63:0] oh;
    if (gnt_vld_o && !prev_vld) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_grant got idx=%0d, required no grant", gnt_idx_o);
      end else begin
        e  = exp_q.pop_front();
        oh = 64'd1 << e;
        if (gnt_idx_o !== e || gnt_o !== oh) begin
          tests_failed++;
          $display("FAIL grant_idx got idx=%0d gnt=%h, required idx=%0d gnt=%h",
                   gnt_idx_o, gnt_o, e, oh);
        end
      end
    end
    prev_vld = gnt_vld_o;
  end

  task automatic do_reset();
    rst_n_i = 1'b0;
    req_i   = '0;
    en_i    = 1'b0;
    rel_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    exp_q.delete();
    m_ptr = '0;
  endtask

  // Request, wait for the grant, optionally hold while disturbing inputs, then release.
  task automatic grant_and_release(input logic [63:0] req, input int hold,
                                   output int idle_wait, output logic [5:0] fp_idx);
    logic [5:0] w;
    bit         got;
    req_i = req;
    en_i  = 1'b1;
    w = model_win(req, m_ptr);
    exp_q.push_back(w);
    idle_wait = 0;
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk_i);
      if (gnt_vld_o) got = 1;
      else idle_wait++;
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL grant_timeout req=%h got vld=0, required vld=1", req);
    end
    fp_idx = idx_fp;
    for (int h = 0; h < hold; h++) begin
      req_i = {$urandom, $urandom} & ~(64'd1 << w);
      en_i  = ~en_i;
      @(negedge clk_i);
      tests_run++;
      if (gnt_vld_o !== 1'b1 || gnt_idx_o !== w) begin
        tests_failed++;
        $display("FAIL grant_hold got vld=%b idx=%0d, required vld=1 idx=%0d",
                 gnt_vld_o, gnt_idx_o, w);
      end
    end
    rel_i = 1'b1;
    en_i  = 1'b1;
    @(posedge clk_i);
    #1;
    rel_i = 1'b0;
    req_i = '0;
    m_ptr = w + 6'd1;
    @(negedge clk_i);
    tests_run++;
    if (gnt_vld_o !== 1'b0 || gnt_o !== 64'd0 || gnt_idx_o !== 6'd0 || to_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL release got vld=%b gnt=%h idx=%0d to=%b, required all 0",
               gnt_vld_o, gnt_o, gnt_idx_o, to_o);
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    req_i   = '1;
    en_i    = 1'b1;
    repeat (3) @(negedge clk_i);
    tests_run++;
    if (gnt_o !== 64'd0 || gnt_vld_o !== 1'b0 || gnt_idx_o !== 6'd0 || to_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs got gnt=%h vld=%b idx=%0d to=%b, required all 0",
               gnt_o, gnt_vld_o, gnt_idx_o, to_o);
    end
    do_reset();
    repeat (3) @(negedge clk_i);
    tests_run++;
    if (gnt_vld_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_no_req got vld=%b, required 0", gnt_vld_o);
    end
  endtask

  task automatic test_basic();
    int         iw;
    logic [5:0] fp;
    grant_and_release(64'h11, 0, iw, fp);
    grant_and_release(64'h11, 0, iw, fp);
  endtask

  task automatic test_rotation();
    int         iw;
    logic [5:0] fp;
    do_reset();
    for (int g = 0; g < 65; g++) begin
      grant_and_release({64{1'b1}}, 0, iw, fp);
      if (g > 0) begin
        tests_run++;
        if (iw !== 0) begin
          tests_failed++;
          $display("FAIL idle_gap grant=%0d got extra idle=%0d, required 0", g, iw);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int         iw;
    logic [5:0] fp;
    grant_and_release(64'd1 << 59, 0, iw, fp);
    grant_and_release((64'd1 << 61) | (64'd1 << 3), 0, iw, fp);
    grant_and_release((64'd1 << 61) | (64'd1 << 3), 0, iw, fp);
  endtask

  task automatic test_single_below_ptr();
    int         iw;
    logic [5:0] fp;
    for (int g = 0; g < 3; g++) grant_and_release(64'h2, 0, iw, fp);
  endtask

  task automatic test_fixed_prio();
    int         iw;
    logic [5:0] fp;
    do_reset();
    for (int g = 0; g < 4; g++) begin
      grant_and_release((64'd1 << 5) | (64'd1 << 9), 0, iw, fp);
      tests_run++;
      if (fp !== 6'd5) begin
        tests_failed++;
        $display("FAIL fixed_prio grant=%0d got idx=%0d, required 5", g, fp);
      end
    end
  endtask

  task automatic test_en_gate();
    int         iw;
    logic [5:0] fp;
    bit         bad;
    en_i  = 1'b0;
    req_i = 64'hF0;
    bad = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (gnt_vld_o !== 1'b0) bad = 1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL en_gate got vld=1 with en_i=0, required 0");
    end
    grant_and_release(64'hF0, 0, iw, fp);
  endtask

  task automatic test_hold();
    int         iw;
    logic [5:0] fp;
    grant_and_release(64'h80, 4, iw, fp);
  endtask

  task automatic test_async_reset();
    int         iw;
    logic [5:0] fp;
    logic [5:0] w;
    grant_and_release(64'd1 << 20, 0, iw, fp);
    req_i = 64'd1 << 30;
    en_i  = 1'b1;
    w = model_win(req_i, m_ptr);
    exp_q.push_back(w);
    repeat (2) @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    tests_run++;
    if (gnt_o !== 64'd0 || gnt_vld_o !== 1'b0 || gnt_idx_o !== 6'd0) begin
      tests_failed++;
      $display("FAIL async_reset got gnt=%h vld=%b idx=%0d, required all 0",
               gnt_o, gnt_vld_o, gnt_idx_o);
    end
    req_i = '0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    m_ptr = '0;
    grant_and_release((64'd1 << 5) | (64'd1 << 25), 0, iw, fp);
  endtask

`ifdef ARB_WDT_EN
  task automatic test_watchdog();
    int         hi;
    bit         fell;
    int         iw;
    logic [5:0] fp;
    do_reset();
    req_i = 64'h4;
    en_i  = 1'b1;
    exp_q.push_back(model_win(req_i, m_ptr));
    hi = 0;
    fell = 0;
    for (int i = 0; i < 20 && !fell; i++) begin
      @(negedge clk_i);
      if (gnt_vld_o) begin
        hi++;
        req_i = '0;
      end else if (hi > 0) begin
        fell = 1;
      end
    end
    tests_run++;
    if (!fell || hi !== WDT || to_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL wdt_fire got fell=%0d high_cycles=%0d to=%b, required 1 %0d 1",
               fell, hi, to_o, WDT);
    end
    @(negedge clk_i);
    tests_run++;
    if (to_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL wdt_pulse_width got to=%b, required 0", to_o);
    end
    m_ptr = 6'd3;
    grant_and_release(64'h12, 0, iw, fp);

    req_i = 64'd1 << 10;
    exp_q.push_back(model_win(req_i, m_ptr));
    hi = 0;
    for (int i = 0; i < 20 && hi < WDT; i++) begin
      @(negedge clk_i);
      if (gnt_vld_o) begin
        hi++;
        req_i = '0;
      end
    end
    rel_i = 1'b1;
    @(posedge clk_i);
    #1;
    rel_i = 1'b0;
    m_ptr = 6'd11;
    @(negedge clk_i);
    tests_run++;
    if (hi !== WDT || gnt_vld_o !== 1'b0 || to_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL wdt_rel_on_limit got high_cycles=%0d vld=%b to=%b, required %0d 0 0",
               hi, gnt_vld_o, to_o, WDT);
    end
  endtask
`else
  task automatic test_watchdog();
    bit bad;
    bit got;
    do_reset();
    req_i = 64'h4;
    en_i  = 1'b1;
    exp_q.push_back(model_win(req_i, m_ptr));
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk_i);
      if (gnt_vld_o) got = 1;
    end
    req_i = '0;
    bad = !got;
    repeat (20) begin
      @(negedge clk_i);
      if (gnt_vld_o !== 1'b1 || to_o !== 1'b0) bad = 1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL no_wdt_hold got vld=%b to=%b, required vld=1 to=0", gnt_vld_o, to_o);
    end
    rel_i = 1'b1;
    @(posedge clk_i);
    #1;
    rel_i = 1'b0;
    m_ptr = 6'd3;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_rotation();
    test_wrap();
    test_single_below_ptr();
    test_fixed_prio();
    test_en_gate();
    test_hold();
    test_async_reset();
    test_watchdog();
    repeat (3) @(negedge clk_i);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
